usb_tx_drain: RTL and testbench

USB_TX_DRAIN -- requirements
Module: usb_tx_drain

---
 rtl/usb_tx_drain_pkg.sv | 25 ++
 rtl/usb_tx_drain_sync_fifo.sv | 67 ++++++
 rtl/usb_tx_drain.sv | 167 ++++++++++++++++
 tb/tb_usb_tx_drain.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_drain_pkg.sv
// usb_tx_drain_pkg
// Shared definitions for the FT245 transmit drain: FSM state encoding,
// parameter defaults, packetizer word layout and pulse-counter width.
package usb_tx_drain_pkg;

  localparam int unsigned DEPTH_DEF    = 64;
  localparam int unsigned WR_PULSE_DEF = 2;
  localparam int unsigned SI_PULSE_DEF = 2;

  // Packetizer word: [8] = 1 payload byte in [7:0], 0 packet-end marker.
  localparam int unsigned MARKER_BIT   = 8;
  localparam int unsigned WORD_W       = 9;

  // Width of the WR / SI pulse down-counter.
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_SEND_IMM = 3'd4
  } state_t;

endpackage

// File: rtl/usb_tx_drain_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with combinational head read (o_rdata shows the entry
// at the read pointer). A push while full is accepted only when a pop
// happens in the same cycle. Pointers wrap modulo DEPTH.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push, i_wdata  write request and data
//   i_pop          read request (ignored when empty)
//   o_rdata        head entry
//   o_count        occupancy 0..DEPTH
//   o_empty/o_full occupancy flags
module sync_fifo
  import usb_tx_drain_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot at the same edge, so a full FIFO can still accept.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/usb_tx_drain.sv
// usb_tx_drain
// Drains packetizer words from a FIFO into an FT245 parallel USB FIFO.
// Payload bytes are written with a SETUP / STROBE / HOLD sequence on
// usb_wr; packet-end markers produce a send-immediate pulse on usb_si_n.
// Words arriving while the FIFO is full are dropped and counted.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_data/in_valid packetizer word stream (no backpressure)
//   usb_txe_n        FT245 TXE#, asynchronous, low = room available
//   clear_overflow   clears overflow and drop_count
//   usb_data/usb_wr  FT245 data bus and write strobe
//   usb_si_n         FT245 send-immediate, active low
//   fill_level       FIFO occupancy
//   overflow         sticky drop flag
//   drop_count       dropped-word count, saturating at 255
module usb_tx_drain
  import usb_tx_drain_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned WR_PULSE = WR_PULSE_DEF,
  parameter int unsigned SI_PULSE = SI_PULSE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_valid,
  input  logic                   usb_txe_n,
  input  logic                   clear_overflow,
  output logic [7:0]             usb_data,
  output logic                   usb_wr,
  output logic                   usb_si_n,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  // TXE# synchronizer; idles high (no room) out of reset.
  logic r_txe_meta;
  logic r_txe_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
    end else begin
      r_txe_meta <= usb_txe_n;
      r_txe_s    <= r_txe_meta;
    end
  end

  // FIFO
  logic [WORD_W-1:0] w_head;
  logic [ADDR_W:0]   w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Overflow tracking; clear wins over a drop in the same cycle.
  logic       w_drop;
  logic       r_overflow;
  logic [7:0] r_drop_cnt;

  assign w_drop = in_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Transmit FSM
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]         r_data;
  logic               r_wr;
  logic               r_si_n;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !r_txe_s) begin
          w_pop = 1'b1;
          if (w_head[MARKER_BIT]) begin
            w_state_nxt = ST_SETUP;
          end else begin
            w_state_nxt = ST_SEND_IMM;
            w_cnt_nxt   = CNT_W'(SI_PULSE - 1);
          end
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_STROBE;
        w_cnt_nxt   = CNT_W'(WR_PULSE - 1);
      end
      ST_STROBE: begin
        if (r_cnt == '0) w_state_nxt = ST_HOLD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      ST_SEND_IMM: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the
  // state register and are free of decode glitches. usb_data is loaded
  // only when a payload byte is popped; markers leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_si_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr    <= (w_state_nxt == ST_STROBE);
      r_si_n  <= (w_state_nxt != ST_SEND_IMM);
      if (w_pop && w_head[MARKER_BIT]) r_data <= w_head[7:0];
    end
  end

  assign usb_data   = r_data;
  assign usb_wr     = r_wr;
  assign usb_si_n   = r_si_n;
  assign fill_level = w_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_usb_tx_drain.sv
// tb_usb_tx_drain
// Directed and randomized checks of usb_tx_drain. A monitor turns the FT245
// pins into a stream of delivered words (bytes as {1,data}, packet ends as
// 9'h000) and pulse widths; the main sequence compares that stream with the
// words the bench expects to have been accepted.
module tb_usb_tx_drain;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned WR_PULSE = 2;
  localparam int unsigned SI_PULSE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] in_data;
  logic       in_valid;
  logic       usb_txe_n;
  logic       clear_overflow;
  logic [7:0] usb_data;
  logic       usb_wr;
  logic       usb_si_n;
  logic [6:0] fill_level;
  logic       overflow;
  logic [7:0] drop_count;

  usb_tx_drain #(
    .DEPTH    (DEPTH),
    .WR_PULSE (WR_PULSE),
    .SI_PULSE (SI_PULSE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .usb_txe_n      (usb_txe_n),
    .clear_overflow (clear_overflow),
    .usb_data       (usb_data),
    .usb_wr         (usb_wr),
    .usb_si_n       (usb_si_n),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         wr_lens[$];
  int         si_lens[$];
  int         wr_run = 0;
  int         si_run = 0;
  int         overlap_err = 0;
  int         stab_err = 0;
  logic       prev_wr = 1'b0;
  logic       prev_si_n = 1'b1;
  logic [7:0] prev_data = '0;

  // Pin monitor
  always @(negedge clk) begin
    if (usb_wr && !prev_wr)      obs_q.push_back({1'b1, usb_data});
    if (!usb_si_n && prev_si_n)  obs_q.push_back(9'h000);
    if (usb_wr) wr_run++;
    else if (prev_wr) begin wr_lens.push_back(wr_run); wr_run = 0; end
    if (!usb_si_n) si_run++;
    else if (!prev_si_n) begin si_lens.push_back(si_run); si_run = 0; end
    if (usb_wr && !usb_si_n) overlap_err++;
    if (usb_wr && prev_wr && usb_data !== prev_data) stab_err++;
    prev_wr   = usb_wr;
    prev_si_n = usb_si_n;
    prev_data = usb_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the word is sampled at the following posedge.
  task automatic push(input logic [8:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [8:0] norm(input logic [8:0] w);
    return w[8] ? w : 9'h000;
  endfunction

  function automatic logic [8:0] rand_word(input int marker_odds);
    logic [8:0] w;
    w = 9'($urandom);
    w[8] = ($urandom_range(0, marker_odds) != 0);
    return w;
  endfunction

  task automatic wait_obs(input int n, input int budget, input string tag);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, obs_q.size(), n);
    tick(WR_PULSE + 4);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_widths(input string tag);
    int bad = 0;
    foreach (wr_lens[i]) if (wr_lens[i] != WR_PULSE) bad++;
    foreach (si_lens[i]) if (si_lens[i] != SI_PULSE) bad++;
    check({tag, "_pulse_widths"}, bad, 0);
    check({tag, "_wr_during_si"}, overlap_err, 0);
    check({tag, "_data_stable"}, stab_err, 0);
    wr_lens.delete();
    si_lens.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    logic [4:0] wr_seq;
    logic [8:0] w;
    int         n0;

    // Reset, with in_valid active to show it is ignored
    rst = 1'b1; in_valid = 1'b1; in_data = 9'h155;
    usb_txe_n = 1'b0; clear_overflow = 1'b0;
    tick(3);
    check("rst_usb_wr",   usb_wr, 0);
    check("rst_usb_si_n", usb_si_n, 1);
    check("rst_fill",     fill_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops",    drop_count, 0);
    check("rst_usb_data", usb_data, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick(3);

    // Single byte: push at edge N, wr high after edges N+2 and N+3
    in_valid = 1'b1; in_data = 9'h1A5;
    @(negedge clk);
    in_valid = 1'b0;
    check("single_fill1", fill_level, 1);
    wr_seq = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      wr_seq[k-1] = usb_wr;
      if (k == 2) check("single_data", usb_data, 8'hA5);
    end
    check("single_wr_timing", wr_seq, 5'b00110);
    check("single_fill0", fill_level, 0);
    exp_q.push_back(9'h1A5);
    wait_obs(1, 20, "single_wait");
    compare_stream("single");

    // Packet: two bytes then end marker, back to back
    push(9'h10D); exp_q.push_back(9'h10D);
    tick(0);
    in_valid = 1'b1; in_data = 9'h10A; @(negedge clk);
    in_data = 9'h000; @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(9'h10A);
    exp_q.push_back(9'h000);
    wait_obs(3, 40, "pkt_wait");
    compare_stream("pkt");
    check_widths("pkt");

    // Flow control
    usb_txe_n = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      w = {1'b1, 8'($urandom)};
      push(w);
      exp_q.push_back(w);
    end
    tick(10);
    check("fc_fill5", fill_level, 5);
    check("fc_no_wr", obs_q.size(), 0);
    usb_txe_n = 1'b0;
    cnt = 0;
    while (!usb_wr && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("fc_latency_ok", (cnt >= 3 && cnt <= 6), 1);
    wait_obs(5, 60, "fc_wait");
    compare_stream("fc");

    // Overflow: 70 pushes into 64 slots
    usb_txe_n = 1'b1;
    tick(3);
    for (int i = 0; i < 70; i++) begin
      w = rand_word(5);
      in_valid = 1'b1; in_data = w;
      if (i < DEPTH) exp_q.push_back(norm(w));
      @(negedge clk);
    end
    in_valid = 1'b0;
    tick(1);
    check("ovf_fill", fill_level, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 6);
    clear_overflow = 1'b1; @(negedge clk); clear_overflow = 1'b0;
    check("ovf_clear_flag", overflow, 0);
    check("ovf_clear_drops", drop_count, 0);

    // Drop counter saturation
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in_data = rand_word(3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sat_drops", drop_count, 255);
    check("sat_fill", fill_level, DEPTH);

    // Clear in the same cycle as a drop
    in_valid = 1'b1; clear_overflow = 1'b1; in_data = 9'h1EE;
    @(negedge clk);
    in_valid = 1'b0; clear_overflow = 1'b0;
    check("clr_prio_flag", overflow, 0);
    check("clr_prio_drops", drop_count, 0);
    push(9'h1EF);
    check("one_drop_flag", overflow, 1);
    check("one_drop_count", drop_count, 1);
    clear_overflow = 1'b1; @(negedge clk); clear_overflow = 1'b0;
    check("one_drop_clear", drop_count, 0);

    // Full with pop: release TXE#, push on the first pop edge
    // (two synchronizer edges, then the pop edge)
    usb_txe_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    w = 9'h17E;
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(w);
    check("fullpop_fill", fill_level, DEPTH);
    check("fullpop_drops", drop_count, 0);
    check("fullpop_flag", overflow, 0);
    wait_obs(DEPTH + 1, (DEPTH + 1) * (WR_PULSE + 3) + 50, "fullpop_wait");
    compare_stream("fullpop");
    check_widths("fullpop");

    // Randomized packets with random gaps and TXE# toggling
    for (int p = 0; p < 6; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b <= len; b++) begin
        w = (b == len) ? 9'($urandom_range(0, 255)) : {1'b1, 8'($urandom)};
        tick($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) usb_txe_n = ~usb_txe_n;
        push(w);
        exp_q.push_back(norm(w));
      end
    end
    usb_txe_n = 1'b0;
    wait_obs(exp_q.size(), 600, "rand_wait");
    compare_stream("rand");
    check_widths("rand");

    // Reset mid-STROBE with queued words and in_valid high during reset
    in_valid = 1'b1;
    in_data = 9'h111; @(negedge clk);
    in_data = 9'h122; @(negedge clk);
    in_data = 9'h133; @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!usb_wr && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rstmid_reached_strobe", usb_wr, 1);
    rst = 1'b1; in_valid = 1'b1; in_data = 9'h1FF;
    @(negedge clk);
    check("rstmid_wr",       usb_wr, 0);
    check("rstmid_si_n",     usb_si_n, 1);
    check("rstmid_fill",     fill_level, 0);
    check("rstmid_drops",    drop_count, 0);
    check("rstmid_overflow", overflow, 0);
    rst = 1'b0; in_valid = 1'b0;
    n0 = obs_q.size();
    tick(30);
    check("rstmid_discarded", obs_q.size(), n0);
    check("rstmid_fill_after", fill_level, 0);
    check("rstmid_idle_wr", usb_wr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
